// File: rtl/sync_release_scheduler.sv
// Synchronization master release scheduler.
// Counts ACCOUNT messages per barrier entry. When an entry reaches its target count, it
// queues a RELEASE multicast to every participating tile. Pending entries are released one
// at a time, lowest index first.
// Optional feature: define SYNC_MASTER_SETUP_CHECK_EN to add the sticky sm_setup_error output,
// which flags ACCOUNTs whose cnt_setup disagrees with the active entry's target.

`ifndef BARRIER_NUMB_FOR_TILE
`define BARRIER_NUMB_FOR_TILE 8
`endif

`ifndef TILE_COUNT
`define TILE_COUNT 16
`endif

package sync_release_scheduler_pkg;
    typedef logic [$clog2(`TILE_COUNT)-1:0] tile_id_t;
    typedef logic [7:0]                     barrier_id_t;
    typedef logic [7:0]                     cnt_barrier_t;
    typedef logic [`TILE_COUNT-1:0]         tile_mask_t;

    typedef struct packed {
        tile_id_t     tile_id_source;
        barrier_id_t  id_barrier;
        cnt_barrier_t cnt_setup;
    } sync_account_message_t;

    typedef struct packed {
        barrier_id_t id_barrier;
    } sync_release_message_t;
endpackage

module sync_release_scheduler
    import sync_release_scheduler_pkg::*;
#(
    parameter int unsigned BARRIER_NUMB = `BARRIER_NUMB_FOR_TILE,
    parameter int unsigned TILE_COUNT   = `TILE_COUNT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  n2c_account_valid,
    input  sync_account_message_t n2c_account_message,
    output logic                  n2c_account_consumed,
    input  logic                  network_available,
`ifdef SYNC_MASTER_SETUP_CHECK_EN
    output logic                  sm_setup_error,
`endif
    output logic                  c2n_release_valid,
    output sync_release_message_t c2n_release_message,
    output tile_mask_t            c2n_release_destination_valid
);

    localparam int unsigned IDX_W = (BARRIER_NUMB > 1) ? $clog2(BARRIER_NUMB) : 1;
    localparam int unsigned ID_W  = $bits(barrier_id_t);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    // Per-entry state
    cnt_barrier_t            cnt_q    [BARRIER_NUMB];
    cnt_barrier_t            target_q [BARRIER_NUMB];
    tile_mask_t              mask_q   [BARRIER_NUMB];
    logic [BARRIER_NUMB-1:0] active_q;
    logic [BARRIER_NUMB-1:0] pend_q;

    // Sender state
    logic [0:0]       state_q;
    logic [IDX_W-1:0] sel_q;
    barrier_id_t      out_id_q;
    tile_mask_t       out_mask_q;

    logic [IDX_W-1:0] acc_idx;
    tile_mask_t       src_bit;
    cnt_barrier_t     cnt_inc;
    cnt_barrier_t     new_cnt;
    cnt_barrier_t     new_target;
    logic             acc_active;
    logic             complete;
    logic             release_fire;
    logic             pend_any;
    logic [IDX_W-1:0] pick_idx;
    logic             unused_id_bits;

    assign acc_idx        = n2c_account_message.id_barrier[IDX_W-1:0];
    assign unused_id_bits = ^n2c_account_message.id_barrier[ID_W-1:IDX_W];
    assign acc_active     = active_q[acc_idx];

    // Accept whenever the addressed entry is not waiting for its RELEASE to go out.
    assign n2c_account_consumed = reset & n2c_account_valid & ~pend_q[acc_idx];

    assign release_fire = (state_q == ST_SEND) & network_available;
    assign pend_any     = |pend_q;

    // Decode the source tile into its mask bit; out-of-range tile ids contribute nothing.
    always_comb begin
        src_bit = '0;
        if (int'(n2c_account_message.tile_id_source) < int'(TILE_COUNT)) begin
            src_bit[n2c_account_message.tile_id_source] = 1'b1;
        end
    end

    // Next count/target for the addressed entry and whether this ACCOUNT completes it.
    always_comb begin
        cnt_inc    = (cnt_q[acc_idx] == '1) ? cnt_q[acc_idx] : cnt_q[acc_idx] + 1'b1;
        new_cnt    = acc_active ? cnt_inc : cnt_barrier_t'(1);
        new_target = acc_active ? target_q[acc_idx] : n2c_account_message.cnt_setup;
        // A setup of 0 or 1 completes on the first ACCOUNT.
        complete   = (new_cnt == new_target) ||
                     (!acc_active && (n2c_account_message.cnt_setup <= cnt_barrier_t'(1)));
    end

    // Lowest-index pending entry; the downward scan leaves the smallest index last.
    always_comb begin
        pick_idx = '0;
        for (int i = int'(BARRIER_NUMB) - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                pick_idx = IDX_W'(i);
            end
        end
    end

    // Entry table: accumulate ACCOUNTs and retire the entry once its RELEASE is taken.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < int'(BARRIER_NUMB); i++) begin
                cnt_q[i]    <= '0;
                target_q[i] <= '0;
                mask_q[i]   <= '0;
            end
            active_q <= '0;
            pend_q   <= '0;
        end else begin
            if (n2c_account_consumed) begin
                cnt_q[acc_idx]    <= new_cnt;
                target_q[acc_idx] <= new_target;
                mask_q[acc_idx]   <= acc_active ? (mask_q[acc_idx] | src_bit) : src_bit;
                if (complete) begin
                    pend_q[acc_idx]   <= 1'b1;
                    active_q[acc_idx] <= 1'b0;
                end else begin
                    active_q[acc_idx] <= 1'b1;
                end
            end
            // The released entry is pending, so it never collides with the accepted one.
            if (release_fire) begin
                pend_q[sel_q] <= 1'b0;
                cnt_q[sel_q]  <= '0;
                mask_q[sel_q] <= '0;
            end
        end
    end

    // Sender FSM: latch one pending entry, then hold it on the NoC until it is accepted.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            sel_q      <= '0;
            out_id_q   <= '0;
            out_mask_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pend_any) begin
                        sel_q      <= pick_idx;
                        out_id_q   <= barrier_id_t'(pick_idx);
                        out_mask_q <= mask_q[pick_idx];
                        state_q    <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (network_available) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign c2n_release_valid             = (state_q == ST_SEND);
    assign c2n_release_message           = sync_release_message_t'(out_id_q);
    assign c2n_release_destination_valid = out_mask_q;

`ifdef SYNC_MASTER_SETUP_CHECK_EN
    logic setup_error_q;

    // Sticky flag: an ACCOUNT to a live entry disagrees with the target it was opened with.
    always_ff @(posedge clk) begin
        if (!reset) begin
            setup_error_q <= 1'b0;
        end else if (n2c_account_consumed && acc_active &&
                     (n2c_account_message.cnt_setup != target_q[acc_idx])) begin
            setup_error_q <= 1'b1;
        end
    end

    assign sm_setup_error = setup_error_q;
`endif

endmodule

// File: tb/tb_sync_release_scheduler.sv
// Scoreboard bench for sync_release_scheduler: directed ACCOUNT sequences push the expected
// RELEASEs; a negedge monitor checks every presented RELEASE against the queue head.
module tb_sync_release_scheduler;
    import sync_release_scheduler_pkg::*;

    logic                  clk;
    logic                  reset;
    logic                  n2c_account_valid;
    sync_account_message_t n2c_account_message;
    logic                  n2c_account_consumed;
    logic                  network_available;
    logic                  c2n_release_valid;
    sync_release_message_t c2n_release_message;
    tile_mask_t            c2n_release_destination_valid;
`ifdef SYNC_MASTER_SETUP_CHECK_EN
    logic                  sm_setup_error;
`endif

    sync_release_scheduler dut (
        .clk                           (clk),
        .reset                         (reset),
        .n2c_account_valid             (n2c_account_valid),
        .n2c_account_message           (n2c_account_message),
        .n2c_account_consumed          (n2c_account_consumed),
        .network_available             (network_available),
`ifdef SYNC_MASTER_SETUP_CHECK_EN
        .sm_setup_error                (sm_setup_error),
`endif
        .c2n_release_valid             (c2n_release_valid),
        .c2n_release_message           (c2n_release_message),
        .c2n_release_destination_valid (c2n_release_destination_valid)
    );

    typedef struct {
        int unsigned id;
        int unsigned mask;
        int          cyc;   // expected first-valid cycle, -1 when not checked
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   hs_cyc = -1;
    int   first_cyc = 0;
    bit   in_send = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int unsigned got, input int unsigned exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic push(input int unsigned id, input int unsigned mask, input int c);
        exp_t e;
        e.id   = id;
        e.mask = mask;
        e.cyc  = c;
        sb.push_back(e);
    endtask

    // Monitor: compare each presented RELEASE with the scoreboard head, pop on handshake.
    always @(negedge clk) begin
        if (!reset) begin
            in_send = 0;
        end else if (c2n_release_valid) begin
            if (!in_send) begin
                in_send   = 1;
                first_cyc = cyc;
            end
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_release: got id %0d mask %0h expected none",
                         c2n_release_message.id_barrier, c2n_release_destination_valid);
            end else begin
                check("release_id", int'(c2n_release_message.id_barrier), sb[0].id);
                check("release_mask", int'(c2n_release_destination_valid), sb[0].mask);
                if (network_available) begin
                    if (sb[0].cyc >= 0) check("release_latency", first_cyc, sb[0].cyc);
                    void'(sb.pop_front());
                    in_send = 0;
                    hs_cyc  = cyc;
                end
            end
        end
    end

    // Called #1 after a rising edge; returns the cycle the ACCOUNT was accepted in.
    task automatic account(input int tile, input int id, input int setup, output int acc_cyc);
        n2c_account_valid                  = 1'b1;
        n2c_account_message.tile_id_source = tile_id_t'(tile);
        n2c_account_message.id_barrier     = barrier_id_t'(id);
        n2c_account_message.cnt_setup      = cnt_barrier_t'(setup);
        acc_cyc = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (n2c_account_consumed) begin
                acc_cyc = cyc;
                break;
            end
        end
        @(posedge clk);
        #1;
        n2c_account_valid = 1'b0;
        if (acc_cyc < 0) check("account_timeout", 0, 1);
    endtask

    task automatic wait_valid();
        bit seen = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (c2n_release_valid) begin
                seen = 1;
                break;
            end
        end
        if (!seen) check("valid_timeout", 0, 1);
    endtask

    task automatic drain();
        bit done = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !c2n_release_valid) begin
                done = 1;
                break;
            end
        end
        check("drain", done, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs();
        @(negedge clk);
        check("rst_valid", c2n_release_valid, 0);
        check("rst_message", int'(c2n_release_message.id_barrier), 0);
        check("rst_mask", int'(c2n_release_destination_valid), 0);
        check("rst_consumed", n2c_account_consumed, 0);
    endtask

    initial begin
        int n;
        int a;
        reset               = 1'b0;
        network_available   = 1'b1;
        n2c_account_valid   = 1'b1;
        n2c_account_message = '0;
        repeat (3) @(posedge clk);
        check_reset_outputs();
        @(posedge clk);
        #1;
        reset             = 1'b1;
        n2c_account_valid = 1'b0;
        @(posedge clk);
        #1;

        // Three tiles, target 3, back to back.
        account(0, 3, 3, n);
        account(1, 3, 3, n);
        account(2, 3, 3, n);
        push(3, 'h0007, n + 2);
        drain();

        // Single-participant barrier.
        account(4, 1, 1, n);
        push(1, 'h0010, n + 2);
        drain();

        // Back-pressure: RELEASE held stable for 4 cycles.
        network_available = 1'b0;
        account(5, 6, 2, n);
        account(9, 6, 2, n);
        push(6, 'h0220, n + 2);
        wait_valid();
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        network_available = 1'b1;
        drain();
        repeat (5) @(posedge clk);
        #1;

        // Priority: entries 5 and 2 both pending behind a stalled RELEASE of 7.
        network_available = 1'b0;
        account(0, 7, 1, n);
        push(7, 'h0001, n + 2);
        wait_valid();
        @(posedge clk);
        #1;
        account(5, 5, 1, n);
        account(2, 2, 1, n);
        push(2, 'h0004, -1);
        push(5, 'h0020, -1);
        @(posedge clk);
        #1;
        network_available = 1'b1;
        drain();

        // ACCOUNT to a pending entry stalls until the cycle after its release.
        network_available = 1'b0;
        account(1, 3, 2, n);
        account(2, 3, 2, n);
        push(3, 'h0006, n + 2);
        fork
            begin
                repeat (4) @(posedge clk);
                #1;
                network_available = 1'b1;
            end
        join_none
        account(8, 3, 2, a);
        check("stall_release_cycle", a, hs_cyc + 1);
        account(9, 3, 2, n);
        push(3, 'h0300, n + 2);
        drain();

        // Mismatched cnt_setup keeps the original target.
        account(0, 4, 2, n);
        account(1, 4, 9, n);
        push(4, 'h0003, n + 2);
        drain();
`ifdef SYNC_MASTER_SETUP_CHECK_EN
        @(negedge clk);
        check("setup_error_set", sm_setup_error, 1);
        account(3, 1, 1, n);
        push(1, 'h0008, n + 2);
        drain();
        @(negedge clk);
        check("setup_error_sticky", sm_setup_error, 1);
        @(posedge clk);
        #1;
`endif

        // Reset during SEND drops the RELEASE.
        network_available = 1'b0;
        account(3, 0, 1, n);
        push(0, 'h0008, n + 2);
        wait_valid();
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb.delete();
        n2c_account_valid   = 1'b1;
        n2c_account_message = '0;
        @(posedge clk);
        check_reset_outputs();
`ifdef SYNC_MASTER_SETUP_CHECK_EN
        check("setup_error_reset", sm_setup_error, 0);
`endif
        @(posedge clk);
        #1;
        reset             = 1'b1;
        n2c_account_valid = 1'b0;
        network_available = 1'b1;
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("no_retransmit", c2n_release_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
